// File: rtl/dr_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : dr_scan_controller
// Description : Front-end between the BSCANE2 user-DR signals and the puzzle
//               solver. 8-bit DR scans become a byte stream held in a
//               first-word-fall-through FIFO. The solver result goes back
//               out serially on tdo during any DR scan.
// Ports       : tck/rst_n            clock, async active-low reset
//               tdi/tdo              scan data in/out, LSB first
//               ir_is_user           user instruction selected
//               capture_dr/shift_dr/update_dr  TAP DR state strobes
//               byte_data/valid/ready  FIFO head toward the solver
//               result/result_valid  solver answer to return on readback
//               fifo_level/overflow  occupancy and sticky drop flag
// Revision    : 1.0 - initial release
// ============================================================================
module dr_scan_controller #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 32,
    parameter int FIFO_DEPTH   = 16    // power of two, >= 2
) (
    input  logic                          tck,
    input  logic                          rst_n,
    input  logic                          tdi,
    output logic                          tdo,
    input  logic                          ir_is_user,
    input  logic                          capture_dr,
    input  logic                          shift_dr,
    input  logic                          update_dr,
    output logic [DATA_WIDTH-1:0]         byte_data,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    input  logic [RESULT_WIDTH-1:0]       result,
    input  logic                          result_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(RESULT_WIDTH + 2);

    localparam logic [CNT_W-1:0] c_CNT_BYTE = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(RESULT_WIDTH + 1);
    localparam logic [PTR_W:0]   c_LVL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Scan sequencing
    // ------------------------------------------------------------------
    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   rx_sr_q;
    logic [RESULT_WIDTH-1:0] tx_sr_q;
    logic [CNT_W-1:0]        bit_cnt_q;

    logic frame_active;
    logic push_req;

    assign frame_active = (state_q != ST_IDLE);

    // The push decision mirrors the priority chain of the FSM below:
    // capture beats shift beats update, and only an exact byte-length
    // frame produces data (readback scans are longer and push nothing).
    assign push_req = ir_is_user & ~capture_dr & ~shift_dr & update_dr &
                      frame_active & (bit_cnt_q == c_CNT_BYTE);

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
            bit_cnt_q <= '0;
        end else if (!ir_is_user) begin
            state_q <= ST_IDLE;
        end else if (capture_dr) begin
            // Capture restarts the frame from any state; the result is
            // latched here so later changes cannot disturb the readback.
            state_q   <= ST_ARMED;
            bit_cnt_q <= '0;
            tx_sr_q   <= result_valid ? result : '0;
        end else if (frame_active && shift_dr) begin
            state_q <= ST_SHIFT;
            rx_sr_q <= {tdi, rx_sr_q[DATA_WIDTH-1:1]};
            tx_sr_q <= {1'b0, tx_sr_q[RESULT_WIDTH-1:1]};
            if (bit_cnt_q != c_CNT_MAX) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
        end else if (frame_active && update_dr) begin
            state_q <= ST_IDLE;
        end
    end

    // tdo comes straight from the register so bit k is stable across the
    // falling edge the host samples on.
    assign tdo = ir_is_user & frame_active & tx_sr_q[0];

    // ------------------------------------------------------------------
    // Byte FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W:0]        level_q;
    logic                  overflow_q;

    logic fifo_full;
    logic fifo_empty;
    logic pop_req;
    logic push_ok;

    assign fifo_full  = (level_q == c_LVL_FULL);
    assign fifo_empty = (level_q == '0);
    assign pop_req    = byte_ready & ~fifo_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO is
    // still accepted in that cycle.
    assign push_ok    = push_req & (~fifo_full | pop_req);

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_req) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_req})
                2'b10:   level_q <= level_q + (PTR_W + 1)'(1);
                2'b01:   level_q <= level_q - (PTR_W + 1)'(1);
                default: level_q <= level_q;
            endcase
            if (push_req && fifo_full && !pop_req) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge tck) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= rx_sr_q;
        end
    end

    assign byte_valid = ~fifo_empty;
    assign byte_data  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: doc/dr_scan_controller.md
# dr_scan_controller

Sequencing front-end between the BSCANE2 user-DR signals and the puzzle solver inside `user_logic`. It turns 8-bit DR scans into a byte stream buffered in a FIFO with valid/ready toward the solver. It also returns the solver result serially on `tdo` during any other DR scan. One instance sits directly behind the BSCAN port; the solver never sees JTAG state signals.

## Interface

Parameters:
- `DATA_WIDTH`, 8, bits per input scan (one character).
- `RESULT_WIDTH`, 32, bits of result returned per readback scan.
- `FIFO_DEPTH`, 16, byte FIFO entries; power of two, ≥2.

Ports:
- `tck`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tdi`  in  1  scan data in, LSB first.
- `tdo`  out  1  scan data out.
- `ir_is_user`  in  1  user instruction selected; gates all scan activity.
- `capture_dr`  in  1  TAP in Capture-DR.
- `shift_dr`  in  1  TAP in Shift-DR.
- `update_dr`  in  1  TAP in Update-DR.
- `byte_data`  out  DATA_WIDTH  FIFO head.
- `byte_valid`  out  1  FIFO not empty.
- `byte_ready`  in  1  solver pops the head when `byte_valid & byte_ready`.
- `result`  in  RESULT_WIDTH  solver answer.
- `result_valid`  in  1  `result` final.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- `overflow`  out  1  sticky: a byte was dropped.

## Operation

- FSM states:
  - IDLE → ARMED on `capture_dr & ir_is_user`.
  - ARMED/SHIFT → SHIFT on `shift_dr & ir_is_user`.
  - ARMED/SHIFT → IDLE on `update_dr`.
  - `capture_dr & ir_is_user` in any state re-enters ARMED; the current frame restarts.
- When `ir_is_user=0`, capture/shift/update inputs are ignored, state is forced to IDLE, and `tdo`=0.
- On capture:
  - `bit_cnt` ← 0.
  - `tx_sr` ← `result` if `result_valid`, else 0.
- On each shift:
  - `rx_sr` ← {`tdi`, `rx_sr[DATA_WIDTH-1:1]`}.
  - `tx_sr` ← {0, `tx_sr[RESULT_WIDTH-1:1]`}.
  - `bit_cnt` increments, saturating at RESULT_WIDTH+1.
- On update in ARMED/SHIFT, when `bit_cnt == DATA_WIDTH` exactly: push `rx_sr` into the FIFO.
  - Any other count (0, 7, 32, …) pushes nothing; readback scans never produce bytes.
  - `update_dr` in IDLE is ignored.
- `tdo` = `tx_sr[0]`, combinational from the register, whenever state ≠ IDLE and `ir_is_user`=1; otherwise 0.
- FIFO behaviour:
  - First-word-fall-through; `byte_data` = head entry whenever `byte_valid`.
  - Push while full and no pop in the same cycle: byte dropped, `overflow` ← 1 until reset.
  - Push while full with a pop in the same cycle: push accepted, level unchanged.
  - Pop when empty: no-op.
- Pointers wrap modulo FIFO_DEPTH; `fifo_level` is the occupancy count, range 0..FIFO_DEPTH.

## Timing

- Reset values: state IDLE, `tdo`=0, `byte_valid`=0, `byte_data`=0, `fifo_level`=0, `overflow`=0, `rx_sr`=`tx_sr`=`bit_cnt`=0.
- Asserting `rst_n`=0 mid-scan aborts the frame immediately and empties the FIFO.
- Byte latency: `update_dr` sampled at edge N → `byte_valid`=1 and `fifo_level` incremented from just after edge N.
- Pop: `byte_valid & byte_ready` at edge N → next entry or `byte_valid`=0 after edge N.
- Readback bit k (k=0..RESULT_WIDTH-1):
  - Valid on `tdo` after the capture edge plus k shift edges.
  - Stable across the following falling edge, where the host samples it.
- `result`/`result_valid` are sampled only at the capture edge; later changes do not alter a scan in progress.

## Test plan

1. Scan 0x41 LSB first: capture, 8 shifts, exit, update, with `byte_ready`=0.
   → `byte_valid`=1, `byte_data`=0x41, `fifo_level`=1. Raise `byte_ready` one cycle → `byte_valid`=0, level 0.
2. `result`=0x0000_0A2B, `result_valid`=1; 32-bit scan with `tdi`=0.
   → `tdo` bits assemble to 0x0000_0A2B; no push, `fifo_level` stays 0.
3. `result_valid`=0 during capture; 32-bit scan.
   → all 32 `tdo` bits 0.
4. `byte_ready`=0; scan 17 bytes 0x00..0x10 with FIFO_DEPTH=16.
   → level 16, `overflow`=1. Drain yields 0x00..0x0F in order; 0x10 absent.
5. FIFO full; `byte_ready`=1 held so a pop coincides with the update edge of byte 0x55.
   → push accepted, level stays 16, `overflow`=0, 0x55 drained last.
6. Three directed cases:
   - `ir_is_user`=0 with a full 8-bit scan+update → no push, `tdo`=0.
   - 7-bit scan → no push.
   - `rst_n` pulsed low after 4 shifts of a byte scan → FIFO empty, state IDLE, and the next 8-bit scan of 0x0A delivers exactly 0x0A.
